// File: rtl/adc_pkg.sv
// adc_pkg: scan/frame state encodings, TLC2543 command-format constants and
// the shared data width, imported by every adc_scan_ctrl file.
package adc_pkg;

  localparam int DATA_W   = 12;
  localparam int CMD_W    = 8;
  localparam int SCK_BITS = 12;

  // Low nibble of the command byte: 12-bit word, MSB first, unipolar.
  localparam logic [3:0] FMT_12B_MSB_UNI = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FRAME    = 2'd1,
    ST_WAIT_EOC = 2'd2
  } scan_state_e;

  typedef enum logic [2:0] {
    FR_IDLE  = 3'd0,
    FR_SETUP = 3'd1,
    FR_HIGH  = 3'd2,
    FR_LOW   = 3'd3,
    FR_HOLD  = 3'd4
  } frame_state_e;

  function automatic logic [CMD_W-1:0] build_cmd(input logic [3:0] ch, input logic [3:0] fmt);
    return {ch, fmt};
  endfunction

endpackage

// File: rtl/adc_scan_ctrl_if.sv
// adc_scan_ctrl_if: control, ADC serial and result signals of adc_scan_ctrl.
// The err signal exists only when ADC_SCAN_TIMEOUT_EN is defined.
interface adc_scan_ctrl_if;
  import adc_pkg::*;

  logic              start;
  logic              cont;
  logic              sdo;
  logic              eoc;
  logic              cs_n;
  logic              sck;
  logic              sdi;
  logic [DATA_W-1:0] dout;
  logic [3:0]        dout_ch;
  logic              dout_vld;
  logic              busy;
  logic              done;
`ifdef ADC_SCAN_TIMEOUT_EN
  logic              err;
`endif

  modport slave (
`ifdef ADC_SCAN_TIMEOUT_EN
    output err,
`endif
    input  start, cont, sdo, eoc,
    output cs_n, sck, sdi, dout, dout_ch, dout_vld, busy, done
  );

  modport master (
`ifdef ADC_SCAN_TIMEOUT_EN
    input  err,
`endif
    output start, cont, sdo, eoc,
    input  cs_n, sck, sdi, dout, dout_ch, dout_vld, busy, done
  );

endinterface

// File: rtl/adc_spi_frame.sv
// adc_spi_frame: one TLC2543 transfer (cs_n low, setup, 12 SCK pulses, hold).
// Command bits leave on sdi, sdo is shifted in on each SCK rise.
module adc_spi_frame
  import adc_pkg::*;
#(
  parameter int CLK_DIV   = 7,
  parameter int SETUP_CYC = 75
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [CMD_W-1:0]  cmd_i,
  input  logic              sdo_i,
  output logic              cs_n_o,
  output logic              sck_o,
  output logic              sdi_o,
  output logic [DATA_W-1:0] data_o,
  output logic              done_o
);

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] DIV_LD   = 8'(CLK_DIV - 1);
  localparam logic [3:0] LAST_BIT = 4'(SCK_BITS);

  frame_state_e      state_q;
  logic [7:0]        cnt_q;
  logic [3:0]        bit_q;
  logic [CMD_W-1:0]  cmd_q;
  logic [DATA_W-1:0] shift_q;
  logic              cs_n_q;
  logic              sck_q;
  logic              sdi_q;
  logic              done_q;

  // Frame sequencer: every phase lasts its counter load plus one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FR_IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 4'd0;
      cmd_q   <= '0;
      shift_q <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      sdi_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        FR_IDLE: begin
          if (start_i) begin
            cs_n_q  <= 1'b0;
            sdi_q   <= cmd_i[CMD_W-1];
            cmd_q   <= {cmd_i[CMD_W-2:0], 1'b0};
            cnt_q   <= SETUP_LD;
            bit_q   <= 4'd0;
            state_q <= FR_SETUP;
          end
        end
        FR_SETUP: begin
          if (cnt_q == 8'd0) begin
            sck_q   <= 1'b1;
            shift_q <= {shift_q[DATA_W-2:0], sdo_i};
            bit_q   <= bit_q + 4'd1;
            cnt_q   <= DIV_LD;
            state_q <= FR_HIGH;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        FR_HIGH: begin
          // Next command bit goes out with the falling edge; zeros follow bit 8.
          if (cnt_q == 8'd0) begin
            sck_q   <= 1'b0;
            sdi_q   <= cmd_q[CMD_W-1];
            cmd_q   <= {cmd_q[CMD_W-2:0], 1'b0};
            cnt_q   <= DIV_LD;
            state_q <= FR_LOW;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        FR_LOW: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else if (bit_q == LAST_BIT) begin
            cnt_q   <= DIV_LD;
            state_q <= FR_HOLD;
          end else begin
            sck_q   <= 1'b1;
            shift_q <= {shift_q[DATA_W-2:0], sdo_i};
            bit_q   <= bit_q + 4'd1;
            cnt_q   <= DIV_LD;
            state_q <= FR_HIGH;
          end
        end
        FR_HOLD: begin
          if (cnt_q == 8'd0) begin
            cs_n_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= FR_IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          cs_n_q  <= 1'b1;
          sck_q   <= 1'b0;
          sdi_q   <= 1'b0;
          state_q <= FR_IDLE;
        end
      endcase
    end
  end

  assign cs_n_o = cs_n_q;
  assign sck_o  = sck_q;
  assign sdi_o  = sdi_q;
  assign data_o = shift_q;
  assign done_o = done_q;

endmodule

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: sweeps TLC2543 channels 0..CH_NUM-1 (plus a flush frame),
// syncs EOC and registers results. ADC_SCAN_TIMEOUT_EN adds the EOC timeout/err.
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int         CH_NUM    = 4,
  parameter int         CLK_DIV   = 7,
  parameter int         SETUP_CYC = 75,
  parameter logic [3:0] CMD_FMT   = FMT_12B_MSB_UNI,
  parameter int         EOC_TO    = 2000
) (
  input logic            clk,
  input logic            rst,
  adc_scan_ctrl_if.slave bus_io
);

  localparam logic [3:0] LAST_FRAME = 4'(CH_NUM);

  scan_state_e       state_q;
  logic [3:0]        frame_q;
  logic              frm_start_q;
  logic [DATA_W-1:0] dout_q;
  logic [3:0]        dout_ch_q;
  logic              dout_vld_q;
  logic              busy_q;
  logic              done_q;
  logic [1:0]        eoc_sync_q;
  logic              eoc_prev_q;
  logic              eoc_rise_s;
  logic [3:0]        cmd_ch_s;
  logic              frm_done_s;
  logic [DATA_W-1:0] frm_data_s;
`ifdef ADC_SCAN_TIMEOUT_EN
  localparam int            TO_W    = $clog2(EOC_TO + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(EOC_TO - 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            err_q;
`endif

  // Flush frame re-addresses channel 0 so the last channel's result comes out.
  always_comb begin
    if (frame_q == LAST_FRAME) begin
      cmd_ch_s = 4'd0;
    end else begin
      cmd_ch_s = frame_q;
    end
  end

  // EOC synchroniser and edge register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eoc_sync_q <= 2'b00;
      eoc_prev_q <= 1'b0;
    end else begin
      eoc_sync_q <= {eoc_sync_q[0], bus_io.eoc};
      eoc_prev_q <= eoc_sync_q[1];
    end
  end

  assign eoc_rise_s = eoc_sync_q[1] & ~eoc_prev_q;

  // Sweep sequencer with registered result and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      frame_q     <= 4'd0;
      frm_start_q <= 1'b0;
      dout_q      <= '0;
      dout_ch_q   <= 4'd0;
      dout_vld_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ADC_SCAN_TIMEOUT_EN
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      frm_start_q <= 1'b0;
      dout_vld_q  <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus_io.start) begin
            frame_q     <= 4'd0;
            frm_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_FRAME;
`ifdef ADC_SCAN_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
          end
        end
        ST_FRAME: begin
          // Frame 0 returns a stale conversion, so it is never published.
          if (frm_done_s) begin
            state_q <= ST_WAIT_EOC;
            if (frame_q != 4'd0) begin
              dout_q     <= frm_data_s;
              dout_ch_q  <= frame_q - 4'd1;
              dout_vld_q <= 1'b1;
            end
`ifdef ADC_SCAN_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end
        end
        ST_WAIT_EOC: begin
          if (eoc_rise_s) begin
            if (frame_q == LAST_FRAME) begin
              done_q  <= 1'b1;
              frame_q <= 4'd0;
              if (bus_io.cont) begin
                frm_start_q <= 1'b1;
                state_q     <= ST_FRAME;
              end else begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end else begin
              frame_q     <= frame_q + 4'd1;
              frm_start_q <= 1'b1;
              state_q     <= ST_FRAME;
            end
          end
`ifdef ADC_SCAN_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
`endif
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  adc_spi_frame #(
    .CLK_DIV  (CLK_DIV),
    .SETUP_CYC(SETUP_CYC)
  ) u_frame (
    .clk    (clk),
    .rst    (rst),
    .start_i(frm_start_q),
    .cmd_i  (build_cmd(cmd_ch_s, CMD_FMT)),
    .sdo_i  (bus_io.sdo),
    .cs_n_o (bus_io.cs_n),
    .sck_o  (bus_io.sck),
    .sdi_o  (bus_io.sdi),
    .data_o (frm_data_s),
    .done_o (frm_done_s)
  );

  assign bus_io.dout     = dout_q;
  assign bus_io.dout_ch  = dout_ch_q;
  assign bus_io.dout_vld = dout_vld_q;
  assign bus_io.busy     = busy_q;
  assign bus_io.done     = done_q;
`ifdef ADC_SCAN_TIMEOUT_EN
  assign bus_io.err      = err_q;
`endif

endmodule

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 SHALL have parameter CH_NUM, default 4: channels scanned per sweep, legal 1..11, scanned in order 0..CH_NUM-1.
REQ-002 SHALL have parameter CLK_DIV, default 7: clk cycles per SCK half-period, legal 2..255.
REQ-003 SHALL have parameter SETUP_CYC, default 75: clk cycles from cs_n fall to first SCK rise, legal 1..255.
REQ-004 SHALL have parameter CMD_FMT, default 4'b0000: low nibble of the TLC2543 command byte (12-bit, MSB-first, unipolar).
REQ-005 SHALL have parameter EOC_TO, default 2000: EOC timeout in clk cycles (REQ-027).
REQ-006 SHALL have port clk, input, 1: single clock for the whole block.
REQ-007 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-008 SHALL have port start, input, 1: one-cycle request to begin a sweep.
REQ-009 SHALL have port cont, input, 1: continuous mode; sampled at each sweep end.
REQ-010 SHALL have ports sdo input 1 and eoc input 1: ADC serial data out and end-of-conversion.
REQ-011 SHALL have ports cs_n output 1, sck output 1 and sdi output 1: ADC serial interface.
REQ-012 SHALL have ports dout output 12 and dout_ch output 4: conversion result and its channel.
REQ-013 SHALL have port dout_vld, output, 1: one-cycle strobe marking a new dout/dout_ch.
REQ-014 SHALL have ports busy output 1 and done output 1: busy is a level for sweep in progress; done is a one-cycle pulse at sweep end.

Function
REQ-015 SHALL use states IDLE, FRAME and WAIT_EOC: IDLE->FRAME on start; FRAME->WAIT_EOC at frame end; WAIT_EOC->FRAME on EOC rise with frames remaining, else ->IDLE or ->FRAME (new sweep, cont=1).
REQ-016 SHALL run each sweep as CH_NUM+1 frames; frame k (0..CH_NUM-1) sends the channel-k command and the final frame sends the channel-0 command.
REQ-017 SHALL build the command byte as {channel[3:0], CMD_FMT}, sent MSB first on the first 8 SCK rises; sdi is 0 for SCK 9..12.
REQ-018 SHALL, per frame, drive cs_n low for SETUP_CYC cycles, then 12 SCK pulses (high CLK_DIV, low CLK_DIV), hold CLK_DIV cycles, then raise cs_n: frame = SETUP_CYC+24*CLK_DIV+CLK_DIV cycles (250 at defaults).
REQ-019 SHALL present sdi bit n from the start of the low phase preceding SCK rise n, with the first bit presented on the cs_n fall cycle.
REQ-020 SHALL sample sdo on the clk cycle SCK is driven high, MSB first, into a 12-bit shift register.
REQ-021 SHALL discard frame-0 data; for frame k>=1, one cycle after cs_n rises, load dout with the word, set dout_ch=k-1 and pulse dout_vld; dout/dout_ch hold until the next dout_vld.
REQ-022 SHALL sync eoc through two flops plus an edge register; an EOC rise is synced-high and previous-low (3-cycle latency).
REQ-023 SHALL, on EOC rise after the final frame, pulse done for one cycle and go to IDLE if cont=0, or start a new sweep at frame 0 if cont=1.
REQ-024 SHALL ignore start unless in IDLE; busy is 1 in every state except IDLE.
REQ-025 SHALL keep sck low and cs_n high outside FRAME.

Reset
REQ-026 SHALL, on rst (async, any state including mid-frame), set IDLE, cs_n=1, sck=0, sdi=0, dout=0, dout_ch=0, dout_vld=0, busy=0, done=0 and clear all counters and sync flops.

Configuration
REQ-027 SHALL, with ADC_SCAN_TIMEOUT_EN defined, add output err (1 bit, reset 0): EOC_TO cycles in WAIT_EOC without EOC rise forces IDLE, sets err and suppresses done; err clears on the next accepted start.
REQ-028 SHALL, without ADC_SCAN_TIMEOUT_EN, have no err port and no timeout counter: WAIT_EOC waits indefinitely.

Structure
REQ-029 SHALL place the state encoding, TLC2543 command-format constants and data width 12 in package adc_pkg.
REQ-030 SHALL implement one sub-module, adc_spi_frame (one CS/SCK/SDI/SDO frame with start/done handshake); adc_scan_ctrl owns sequencing, EOC sync and output registers.

Verification
REQ-031 SHALL cover default params, start pulse, ADC model returning 12'hA5C per frame with EOC 10 us after cs_n rise -> 4 dout_vld with dout_ch 0,1,2,3, frame length exactly 250 cycles, then done pulse, busy=0.
REQ-032 SHALL cover command bits with CH_NUM=3 and CMD_FMT=4'b0000 -> sdi bytes 8'h00, 8'h10, 8'h20, 8'h00, each sampled on SCK rises 1..8.
REQ-033 SHALL cover cont=1 for 2 sweeps then cont=0 -> 2*CH_NUM dout_vld, 2 done pulses, IDLE after the second done.
REQ-034 SHALL cover start reasserted mid-sweep -> ignored, frame count and dout_ch sequence unchanged.
REQ-035 SHALL cover rst asserted at SCK pulse 6 of frame 2 -> outputs at REQ-026 values the same cycle; a later start runs a full clean sweep.
REQ-036 SHALL cover, with ADC_SCAN_TIMEOUT_EN defined, eoc held low -> err=1 exactly EOC_TO cycles after WAIT_EOC entry, no done, busy=0; the next start clears err.
